mmio_led_pwm: RTL and testbench

Memory-mapped LED/RGB peripheral directly downstream of the processor core in top.
- Accepts word-aligned loads and stores from the core's data-memory port for addresses inside its window.
- Drives the board LED and the three RGB PWM outputs.
- Provides free-running millisecond and microsecond timers for software delays.

---
 rtl/mmio_pkg.sv | 30 +++
 rtl/pwm_channel.sv | 31 +++
 rtl/mmio_led_pwm.sv | 173 +++++++++++++++++
 tb/tb_mmio_led_pwm.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped LED/RGB PWM peripheral.
// Register offsets are word indices, selected by addr[4:2].
package mmio_pkg;

  localparam logic [2:0] OFF_LED      = 3'd0;
  localparam logic [2:0] OFF_DUTY_R   = 3'd1;
  localparam logic [2:0] OFF_DUTY_G   = 3'd2;
  localparam logic [2:0] OFF_DUTY_B   = 3'd3;
  localparam logic [2:0] OFF_PRESCALE = 3'd4;
  localparam logic [2:0] OFF_MILLIS   = 3'd5;
  localparam logic [2:0] OFF_MICROS   = 3'd6;

  localparam logic [31:0] DEF_BASE_ADDR = 32'hFFFF_FF00;

  // About 1 kHz PWM at 12 MHz: 12e6 / (47 * 256).
  localparam logic [15:0] PRESCALE_RST = 16'd46;

  function automatic logic [31:0] merge_bytes(
    input logic [31:0] old_val,
    input logic [31:0] new_val,
    input logic [3:0]  mask
  );
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = mask[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM colour channel: duty shadow that reloads at period start,
// compare against the shared period counter, and a registered output.
module pwm_channel #(
  parameter int unsigned PWM_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [PWM_W-1:0] i_duty,
  input  logic [PWM_W-1:0] i_cnt,
  output logic             o_pwm
);

  logic [PWM_W-1:0] r_shadow;
  logic             r_pwm;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shadow <= '0;
      r_pwm    <= 1'b0;
    end else begin
      if (i_load) begin
        r_shadow <= i_duty;
      end
      r_pwm <= (i_cnt < r_shadow);
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/mmio_led_pwm.sv
// Memory-mapped LED / RGB PWM peripheral with free-running us/ms timers.
// 32-byte register window; registered reads with one cycle of latency.
module mmio_led_pwm
  import mmio_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 12000000,
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int unsigned PWM_W     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        wen,
  input  logic [3:0]  wmask,
  input  logic [31:0] wdata,
  input  logic        ren,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        LED,
  output logic        RGB_R,
  output logic        RGB_G,
  output logic        RGB_B
);

  localparam int unsigned US_DIV  = (CLK_HZ >= 1000000) ? CLK_HZ / 1000000 : 1;
  localparam int unsigned MS_DIV  = (CLK_HZ >= 1000) ? CLK_HZ / 1000 : 1;
  localparam logic [31:0] US_LAST = 32'(US_DIV - 1);
  localparam logic [31:0] MS_LAST = 32'(MS_DIV - 1);

  logic             r_led;
  logic [PWM_W-1:0] r_duty_r;
  logic [PWM_W-1:0] r_duty_g;
  logic [PWM_W-1:0] r_duty_b;
  logic [15:0]      r_prescale;
  logic [15:0]      r_pre_cnt;
  logic [PWM_W-1:0] r_pwm_cnt;
  logic [31:0]      r_us_div;
  logic [31:0]      r_ms_div;
  logic [31:0]      r_micros;
  logic [31:0]      r_millis;
  logic [31:0]      r_rdata;

  logic [2:0]       w_off;
  logic             w_wr;
  logic             w_ps_wr;
  logic [31:0]      w_rd_val;
  logic [31:0]      w_wr_val;
  logic             w_tick;
  logic             w_wrap;
  logic             w_unused_addr;

  assign w_off         = addr[4:2];
  assign hit           = (addr[31:5] == BASE_ADDR[31:5]);
  assign w_wr          = wen & hit;
  assign w_ps_wr       = w_wr && (w_off == OFF_PRESCALE);
  assign w_unused_addr = ^addr[1:0];

  always_comb begin
    w_rd_val = '0;
    case (w_off)
      OFF_LED:      w_rd_val = {31'd0, r_led};
      OFF_DUTY_R:   w_rd_val = 32'(r_duty_r);
      OFF_DUTY_G:   w_rd_val = 32'(r_duty_g);
      OFF_DUTY_B:   w_rd_val = 32'(r_duty_b);
      OFF_PRESCALE: w_rd_val = {16'd0, r_prescale};
      OFF_MILLIS:   w_rd_val = r_millis;
      OFF_MICROS:   w_rd_val = r_micros;
      default:      w_rd_val = '0;
    endcase
  end

  // The current value of the addressed register supplies the unmasked bytes.
  assign w_wr_val = merge_bytes(w_rd_val, wdata, wmask);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_led      <= 1'b0;
      r_duty_r   <= '0;
      r_duty_g   <= '0;
      r_duty_b   <= '0;
      r_prescale <= PRESCALE_RST;
    end else if (w_wr) begin
      case (w_off)
        OFF_LED:      r_led      <= w_wr_val[0];
        OFF_DUTY_R:   r_duty_r   <= w_wr_val[PWM_W-1:0];
        OFF_DUTY_G:   r_duty_g   <= w_wr_val[PWM_W-1:0];
        OFF_DUTY_B:   r_duty_b   <= w_wr_val[PWM_W-1:0];
        OFF_PRESCALE: r_prescale <= w_wr_val[15:0];
        default:      ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata <= '0;
    end else if (ren) begin
      r_rdata <= hit ? w_rd_val : 32'd0;
    end
  end

  assign w_tick = (r_pre_cnt == r_prescale);
  assign w_wrap = w_tick && (r_pwm_cnt == '1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pre_cnt <= '0;
      r_pwm_cnt <= '0;
    end else begin
      if (w_ps_wr || w_tick) begin
        r_pre_cnt <= '0;
      end else begin
        r_pre_cnt <= r_pre_cnt + 16'd1;
      end
      if (w_tick) begin
        r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_us_div <= '0;
      r_ms_div <= '0;
      r_micros <= '0;
      r_millis <= '0;
    end else begin
      if (r_us_div == US_LAST) begin
        r_us_div <= '0;
        r_micros <= r_micros + 32'd1;
      end else begin
        r_us_div <= r_us_div + 32'd1;
      end
      if (r_ms_div == MS_LAST) begin
        r_ms_div <= '0;
        r_millis <= r_millis + 32'd1;
      end else begin
        r_ms_div <= r_ms_div + 32'd1;
      end
    end
  end

  pwm_channel #(.PWM_W(PWM_W)) u_ch_r (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_wrap),
    .i_duty (r_duty_r),
    .i_cnt  (r_pwm_cnt),
    .o_pwm  (RGB_R)
  );

  pwm_channel #(.PWM_W(PWM_W)) u_ch_g (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_wrap),
    .i_duty (r_duty_g),
    .i_cnt  (r_pwm_cnt),
    .o_pwm  (RGB_G)
  );

  pwm_channel #(.PWM_W(PWM_W)) u_ch_b (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_wrap),
    .i_duty (r_duty_b),
    .i_cnt  (r_pwm_cnt),
    .o_pwm  (RGB_B)
  );

  assign rdata = r_rdata;
  assign LED   = r_led;

endmodule

// File: tb/tb_mmio_led_pwm.sv
// Self-checking bench for mmio_led_pwm: constant vector table, randomized
// register traffic against a reference model, and PWM/reset sequences.
module tb_mmio_led_pwm;

  localparam logic [31:0] B = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = '0;
  logic        wen = 1'b0;
  logic [3:0]  wmask = '0;
  logic [31:0] wdata = '0;
  logic        ren = 1'b0;
  logic [31:0] rdata;
  logic        hit;
  logic        LED;
  logic        RGB_R;
  logic        RGB_G;
  logic        RGB_B;

  int n_tests = 0;
  int n_fail  = 0;

  longint unsigned n_edges;
  logic [31:0]     model [0:4];
  logic [31:0]     last_rd;

  typedef struct {
    bit          we;
    bit          re;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  wm;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 30;
  vec_t tbl [0:NV-1];

  mmio_led_pwm #(.CLK_HZ(12000000), .BASE_ADDR(B), .PWM_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .wen   (wen),
    .wmask (wmask),
    .wdata (wdata),
    .ren   (ren),
    .rdata (rdata),
    .hit   (hit),
    .LED   (LED),
    .RGB_R (RGB_R),
    .RGB_G (RGB_G),
    .RGB_B (RGB_B)
  );

  always #5 clk = ~clk;

  // Clock edges seen with reset high: the timers are plain quotients of this.
  always @(posedge clk or negedge reset) begin
    if (!reset) n_edges <= 0;
    else        n_edges <= n_edges + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "bench timed out");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  function automatic bit in_window(input logic [31:0] a);
    return (a >= B) && ((a - B) < 32'd32);
  endfunction

  function automatic logic [31:0] field_mask(input int off);
    case (off)
      0:       return 32'h0000_0001;
      1, 2, 3: return 32'h0000_00FF;
      4:       return 32'h0000_FFFF;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int off;
    if (!in_window(a)) return 32'h0;
    off = int'((a - B) >> 2);
    case (off)
      0, 1, 2, 3, 4: return model[off];
      5:             return 32'(n_edges / 12000);
      6:             return 32'(n_edges / 12);
      default:       return 32'h0;
    endcase
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wm);
    int          off;
    logic [31:0] bm;
    if (!in_window(a)) return;
    off = int'((a - B) >> 2);
    if (off > 4) return;
    bm = {{8{wm[3]}}, {8{wm[2]}}, {8{wm[1]}}, {8{wm[0]}}};
    model[off] = ((model[off] & ~bm) | (wd & bm)) & field_mask(off);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) model[i] = 32'h0;
    model[4] = 32'd46;
    last_rd  = 32'h0;
  endtask

  // One bus cycle; rdata is expected to hold when no read is issued.
  task automatic do_op(input bit we, input bit re, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] wm, input logic [31:0] exp_tbl, input bit use_model,
                       input string name);
    logic [31:0] exp_rd;
    @(negedge clk);
    addr = a; wen = we; ren = re; wdata = wd; wmask = wm;
    if (!re)            exp_rd = last_rd;
    else if (use_model) exp_rd = model_read(a);
    else                exp_rd = exp_tbl;
    #1;
    check({name, " hit"}, {31'd0, hit}, {31'd0, in_window(a)});
    @(posedge clk);
    #1;
    wen = 1'b0; ren = 1'b0;
    if (we) model_write(a, wd, wm);
    check({name, " rdata"}, rdata, exp_rd);
    last_rd = exp_rd;
    check({name, " LED"}, {31'd0, LED}, {31'd0, model[0][0]});
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    do_op(1'b1, 1'b0, a, d, 4'hF, 32'h0, 1'b1, "wr");
  endtask

  function automatic logic rgb(input int idx);
    case (idx)
      0:       return RGB_R;
      1:       return RGB_G;
      default: return RGB_B;
    endcase
  endfunction

  task automatic count_high(input int idx, input int ncyc, output int cnt);
    cnt = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk);
      #1;
      cnt += int'(rgb(idx));
    end
  endtask

  // Returns at the sample where the output first goes high in a period.
  task automatic find_rise(input int idx, output bit found);
    logic prev;
    found = 1'b0;
    @(posedge clk);
    #1;
    prev = rgb(idx);
    for (int i = 0; i < 600 && !found; i++) begin
      @(posedge clk);
      #1;
      if (rgb(idx) && !prev) found = 1'b1;
      prev = rgb(idx);
    end
  endtask

  task automatic duty_run(input int idx, input logic [31:0] a, input int duty, input string name);
    int c;
    wr(a, 32'(duty));
    repeat (520) @(posedge clk);
    count_high(idx, 256, c);
    check(name, 32'(c), 32'(duty));
  endtask

  initial begin
    int c;
    int c1;
    int c2;
    bit found;

    tbl[0]  = '{1, 0, B + 32'h04, 32'hA5A5_A5A5, 4'b0001, 32'h0};
    tbl[1]  = '{0, 1, B + 32'h04, 32'h0,         4'b0000, 32'h0000_00A5};
    tbl[2]  = '{1, 0, B + 32'h08, 32'h1234_5678, 4'b1111, 32'h0};
    tbl[3]  = '{0, 1, B + 32'h08, 32'h0,         4'b0000, 32'h0000_0078};
    tbl[4]  = '{1, 0, B + 32'h10, 32'hDEAD_BEEF, 4'b0010, 32'h0};
    tbl[5]  = '{0, 1, B + 32'h10, 32'h0,         4'b0000, 32'h0000_BE2E};
    tbl[6]  = '{1, 0, B + 32'h10, 32'h1234_0005, 4'b0011, 32'h0};
    tbl[7]  = '{0, 1, B + 32'h10, 32'h0,         4'b0000, 32'h0000_0005};
    tbl[8]  = '{1, 0, B + 32'h00, 32'hFFFF_FFFE, 4'b1111, 32'h0};
    tbl[9]  = '{0, 1, B + 32'h00, 32'h0,         4'b0000, 32'h0};
    tbl[10] = '{1, 0, B + 32'h00, 32'h0000_0001, 4'b1110, 32'h0};
    tbl[11] = '{0, 1, B + 32'h00, 32'h0,         4'b0000, 32'h0};
    tbl[12] = '{1, 0, B + 32'h00, 32'h0000_0003, 4'b0001, 32'h0};
    tbl[13] = '{0, 1, B + 32'h00, 32'h0,         4'b0000, 32'h0000_0001};
    tbl[14] = '{0, 1, B + 32'h05, 32'h0,         4'b0000, 32'h0000_00A5};
    tbl[15] = '{0, 1, B + 32'h1C, 32'h0,         4'b0000, 32'h0};
    tbl[16] = '{1, 0, B + 32'h1C, 32'hFFFF_FFFF, 4'b1111, 32'h0};
    tbl[17] = '{0, 1, B + 32'h1C, 32'h0,         4'b0000, 32'h0};
    tbl[18] = '{0, 1, B + 32'h04, 32'h0,         4'b0000, 32'h0000_00A5};
    tbl[19] = '{0, 1, B + 32'h20, 32'h0,         4'b0000, 32'h0};
    tbl[20] = '{1, 0, B + 32'h20, 32'h0,         4'b1111, 32'h0};
    tbl[21] = '{0, 1, B + 32'h00, 32'h0,         4'b0000, 32'h0000_0001};
    tbl[22] = '{1, 1, B + 32'h0C, 32'h0000_0033, 4'b0001, 32'h0};
    tbl[23] = '{0, 1, B + 32'h0C, 32'h0,         4'b0000, 32'h0000_0033};
    tbl[24] = '{0, 1, 32'hFFFF_FEFC, 32'h0,      4'b0000, 32'h0};
    tbl[25] = '{1, 0, B + 32'h14, 32'hFFFF_FFFF, 4'b1111, 32'h0};
    tbl[26] = '{0, 1, B + 32'h14, 32'h0,         4'b0000, 32'h0};
    tbl[27] = '{1, 0, B + 32'h08, 32'h0000_00FF, 4'b0001, 32'h0};
    tbl[28] = '{0, 1, B + 32'h08, 32'h0,         4'b0000, 32'h0000_00FF};
    tbl[29] = '{0, 1, B + 32'h10, 32'h0,         4'b0000, 32'h0000_0005};

    // Reset and timers
    model_reset();
    repeat (5) @(posedge clk);
    #1;
    check("in_reset outs", {28'd0, LED, RGB_R, RGB_G, RGB_B}, 32'h0);
    check("in_reset rdata", rdata, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("first_edge outs", {28'd0, LED, RGB_R, RGB_G, RGB_B}, 32'h0);
    check("first_edge rdata", rdata, 32'h0);
    do_op(1'b0, 1'b1, B + 32'h14, 32'h0, 4'h0, 32'h0, 1'b0, "millis_at_rst");
    while (n_edges < 120) @(negedge clk);
    do_op(1'b0, 1'b1, B + 32'h18, 32'h0, 4'h0, 32'h0, 1'b1, "micros_120");

    // Constant vector table
    for (int i = 0; i < NV; i++) begin
      do_op(tbl[i].we, tbl[i].re, tbl[i].a, tbl[i].wd, tbl[i].wm, tbl[i].exp, 1'b0,
            $sformatf("vec%0d", i));
    end

    // Randomized register traffic
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      int          sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 8)       a = B + ($urandom % 32);
      else if (sel == 8) a = B + 32'h20 + ($urandom % 32);
      else               a = $urandom;
      do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
            4'($urandom_range(0, 15)), 32'h0, 1'b1, $sformatf("rand%0d", i));
    end

    for (int i = 0; i < 20000 && n_edges < 12010; i++) @(negedge clk);
    do_op(1'b0, 1'b1, B + 32'h14, 32'h0, 4'h0, 32'h0, 1'b1, "millis_12k");

    // PWM duty with a tick every cycle
    wr(B + 32'h10, 32'd0);
    duty_run(1, B + 32'h08, 64,  "duty_g64");
    duty_run(1, B + 32'h08, 0,   "duty_g0");
    duty_run(1, B + 32'h08, 255, "duty_g255");
    duty_run(0, B + 32'h04, 1,   "duty_r1");

    // Prescale of 1 doubles the period and the high time
    wr(B + 32'h10, 32'd1);
    wr(B + 32'h08, 32'd64);
    repeat (1100) @(posedge clk);
    count_high(1, 512, c);
    check("prescale1_g64", 32'(c), 32'd128);

    // Duty change mid-period lands at the next period start
    wr(B + 32'h10, 32'd0);
    wr(B + 32'h0C, 32'd200);
    repeat (520) @(posedge clk);
    find_rise(2, found);
    check("rise_b found", {31'd0, found}, 32'd1);
    fork
      begin
        c1 = int'(RGB_B);
        for (int i = 1; i < 256; i++) begin
          @(posedge clk);
          #1;
          c1 += int'(RGB_B);
        end
        count_high(2, 256, c2);
      end
      begin
        repeat (3) @(negedge clk);
        wr(B + 32'h0C, 32'd10);
      end
    join
    check("glitch_cur_period", 32'(c1), 32'd200);
    check("glitch_next_period", 32'(c2), 32'd10);

    // Asynchronous reset in the middle of a PWM period
    wr(B + 32'h00, 32'd1);
    wr(B + 32'h04, 32'd200);
    repeat (520) @(posedge clk);
    find_rise(0, found);
    check("rise_r found", {31'd0, found}, 32'd1);
    repeat (100) @(posedge clk);
    #1;
    check("r_high_cnt100", {31'd0, RGB_R}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst outs", {28'd0, LED, RGB_R, RGB_G, RGB_B}, 32'h0);
    check("async_rst rdata", rdata, 32'h0);
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      do_op(1'b0, 1'b1, B + 32'(4 * i), 32'h0, 4'h0, 32'h0, 1'b1, $sformatf("post_rst%0d", i));
    end
    do_op(1'b0, 1'b1, B + 32'h10, 32'h0, 4'h0, 32'd46, 1'b0, "post_rst_prescale");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
